// File: rtl/mem_responder.sv
// mem_responder: word-addressed memory answering Read/Write strobes.
// Ports: Clock, clear (async high), Read, Write, MAR_addr,
//   MDR_wdata -> Mdatain, Ready (1-cycle pulse), Busy, Fault.
// Optional: MEM_BOUNDS_CHECK_EN enables out-of-range detection.
module mem_responder #(
    parameter int ADDR_W      = 9,
    parameter int DEPTH       = 512,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              Clock,
    input  logic              clear,
    input  logic              Read,
    input  logic              Write,
    input  logic [ADDR_W-1:0] MAR_addr,
    input  logic [31:0]       MDR_wdata,
    output logic [31:0]       Mdatain,
    output logic              Ready,
    output logic              Busy,
    output logic              Fault
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t             state_q;
    logic [3:0]         cnt_q;
    logic [IDX_W-1:0]   idx_q;
    logic [31:0]        wdata_q;
    logic               we_q;
    logic               oor_q;
    logic               oor_d;
    logic [31:0]        rdata_q;
    logic               ready_q;
    logic               busy_q;
    logic               fin;
    logic               mem_we;

    logic [31:0] mem_q [DEPTH];

`ifdef MEM_BOUNDS_CHECK_EN
    logic fault_q;
    assign oor_d = 32'(MAR_addr) >= 32'(DEPTH);
    assign Fault = fault_q;
`else
    // Upper address bits are deliberately dropped: addresses wrap.
    logic unused_hi;
    assign unused_hi = |MAR_addr;
    assign oor_d     = 1'b0;
    assign Fault     = 1'b0;
`endif

    // Completion happens on the edge where the wait counter is exhausted.
    assign fin    = (state_q == BUSY) && (cnt_q == 4'd0);
    assign mem_we = fin && we_q && !oor_q;

    // Memory array is never reset; write only at access completion.
    always_ff @(posedge Clock) begin
        if (mem_we) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    always_ff @(posedge Clock or posedge clear) begin
        if (clear) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            we_q    <= 1'b0;
            oor_q   <= 1'b0;
            rdata_q <= 32'd0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
`ifdef MEM_BOUNDS_CHECK_EN
            fault_q <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (Read || Write) begin
                        idx_q   <= MAR_addr[IDX_W-1:0];
                        wdata_q <= MDR_wdata;
                        // Write wins when both strobes are high.
                        we_q    <= Write;
                        oor_q   <= oor_d;
                        cnt_q   <= 4'(WAIT_CYCLES);
                        busy_q  <= 1'b1;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        if (!we_q) begin
                            rdata_q <= oor_q ? 32'd0 : mem_q[idx_q];
                        end
                        ready_q <= 1'b1;
`ifdef MEM_BOUNDS_CHECK_EN
                        fault_q <= oor_q;
`endif
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
`ifdef MEM_BOUNDS_CHECK_EN
                    fault_q <= 1'b0;
`endif
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Mdatain = rdata_q;
    assign Ready   = ready_q;
    assign Busy    = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder against a transaction-level model.
// Compile with MEM_BOUNDS_CHECK_EN to exercise the bounds-check build.
module tb_mem_responder;

    localparam int AW    = 9;
    localparam int DEPTH = 256;
    localparam int WAIT  = 1;

    logic          Clock = 1'b0;
    logic          clear;
    logic          Read;
    logic          Write;
    logic [AW-1:0] MAR_addr;
    logic [31:0]   MDR_wdata;
    logic [31:0]   Mdatain;
    logic          Ready;
    logic          Busy;
    logic          Fault;

    mem_responder #(
        .ADDR_W      (AW),
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (WAIT)
    ) dut (
        .Clock     (Clock),
        .clear     (clear),
        .Read      (Read),
        .Write     (Write),
        .MAR_addr  (MAR_addr),
        .MDR_wdata (MDR_wdata),
        .Mdatain   (Mdatain),
        .Ready     (Ready),
        .Busy      (Busy),
        .Fault     (Fault)
    );

    always #5 Clock = ~Clock;

    int          vecs = 0;
    int          errs = 0;
    logic [31:0] mem_m [DEPTH];
    logic [31:0] exp_rd = 32'd0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_oor(input logic [AW-1:0] a);
`ifdef MEM_BOUNDS_CHECK_EN
        return int'(a) >= DEPTH;
`else
        return 1'b0;
`endif
    endfunction

    // Starts at a negedge with the DUT idle; returns at a negedge, idle.
    task automatic access(input bit rd, input bit wr,
                          input logic [AW-1:0] a, input logic [31:0] d);
        int n;
        bit got;
        bit oor;
        int idx;
        oor = is_oor(a);
        idx = int'(a) % DEPTH;
        Read = rd;
        Write = wr;
        MAR_addr = a;
        MDR_wdata = d;
        @(posedge Clock);
        #1;
        // Strobe/address noise while in flight must be ignored.
        Read = 1'($urandom);
        Write = 1'($urandom);
        MAR_addr = AW'($urandom);
        MDR_wdata = $urandom;
        n = 0;
        got = 0;
        while (!got && n < 20) begin
            @(negedge Clock);
            n++;
            if (Ready) begin
                got = 1;
            end else begin
                chk("busy", 32'(Busy), 32'd1);
                chk("hold", Mdatain, exp_rd);
            end
        end
        Read = 0;
        Write = 0;
        if (!got) begin
            chk("timeout", 32'd0, 32'd1);
            return;
        end
        if (wr) begin
            if (!oor) mem_m[idx] = d;
        end else begin
            exp_rd = oor ? 32'd0 : mem_m[idx];
        end
        chk("lat", 32'(n), 32'(WAIT + 2));
        chk("rdata", Mdatain, exp_rd);
        chk("fault", 32'(Fault), 32'(oor));
        chk("busy_rdy", 32'(Busy), 32'd1);
        @(negedge Clock);
        chk("rdy_drop", 32'(Ready), 32'd0);
        chk("busy_drop", 32'(Busy), 32'd0);
        chk("fault_drop", 32'(Fault), 32'd0);
        chk("rd_keep", Mdatain, exp_rd);
    endtask

    initial begin
        int rcnt;
        int pos [2];
        bit r;
        bit w;
        clear = 1'b1;
        Read = 0;
        Write = 0;
        MAR_addr = '0;
        MDR_wdata = '0;
        #1;
        chk("rst_data", Mdatain, 32'd0);
        chk("rst_rdy", 32'(Ready), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_fault", 32'(Fault), 32'd0);
        repeat (2) @(negedge Clock);
        clear = 1'b0;

        for (int i = 0; i < DEPTH; i++) begin
            access(0, 1, AW'(i), $urandom);
        end

        access(0, 1, 9'd3, 32'h00000012);
        access(1, 0, 9'd3, 32'd0);
        chk("d_rd3", Mdatain, 32'h00000012);
        access(0, 1, 9'h1FF, 32'h28918000);
        access(1, 0, 9'h1FF, 32'd0);
        access(1, 1, 9'd7, 32'h14);
        access(1, 0, 9'd7, 32'd0);
        chk("d_rd7", Mdatain, 32'h14);
        access(0, 1, 9'd5, 32'hAB);
        access(1, 0, 9'h105, 32'd0);

        // Abort a write in flight with an asynchronous reset.
        access(0, 1, 9'd5, 32'h0BADF00D);
        Write = 1;
        MAR_addr = 9'd5;
        MDR_wdata = 32'hDEADBEEF;
        @(posedge Clock);
        #1;
        Write = 0;
        @(negedge Clock);
        clear = 1'b1;
        #1;
        exp_rd = 32'd0;
        chk("mid_data", Mdatain, 32'd0);
        chk("mid_rdy", 32'(Ready), 32'd0);
        chk("mid_busy", 32'(Busy), 32'd0);
        chk("mid_fault", 32'(Fault), 32'd0);
        @(negedge Clock);
        clear = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clock);
            chk("mid_norpl", 32'(Ready), 32'd0);
        end
        access(1, 0, 9'd5, 32'd0);
        chk("mid_rd5", Mdatain, 32'h0BADF00D);

        // Held Read: DONE ignores it, so acceptances are WAIT+3 apart.
        Read = 1;
        MAR_addr = 9'd3;
        rcnt = 0;
        pos[0] = 0;
        pos[1] = 0;
        for (int n = 1; n <= 2 * WAIT + 6; n++) begin
            @(negedge Clock);
            if (Ready) begin
                if (rcnt < 2) pos[rcnt] = n;
                rcnt++;
                chk("held_data", Mdatain, 32'h00000012);
            end
        end
        Read = 0;
        exp_rd = 32'h00000012;
        chk("held_cnt", 32'(rcnt), 32'd2);
        chk("held_p0", 32'(pos[0]), 32'(WAIT + 2));
        chk("held_p1", 32'(pos[1]), 32'(2 * WAIT + 5));

        for (int i = 0; i < 300; i++) begin
            r = 1'($urandom);
            w = 1'($urandom);
            if (!r && !w) r = 1;
            access(r, w, AW'($urandom), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
